fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decoder. Owns the 8-bit program counter and drives the synchronous program ROM, which has one cycle of read latency. Delivers one 24-bit instruction word per cycle on rom_data, or a NOP bubble when no word is valid. Accepts the decoder's jump request, and supports a stall input and a halt opcode.

Parameters:
RESET_VECTOR, 8'h00, PC value loaded on reset.
NOP_WORD, 24'h000000, word driven on rom_data during bubbles; opcode field must decode as NOP.
HALT_OPCODE, 8'hFF, opcode (bits 23:16) that halts fetch.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, synchronous, active-high.
rom_addr  out  8  ROM read address; equals fetch_pc register (combinational from the register).
rom_rdata  in  24  ROM data; equals ROM[rom_addr of previous cycle].
stall  in  1  hold the current instruction; do not issue it.
jump_enable  in  1  taken jump from the decoder.
jump_data  in  8  jump target.
rom_data  out  24  instruction word to the decoder.
instr_valid  out  1  rom_data carries a real instruction this cycle.
instr_pc  out  8  address of the word on rom_data; 0 when instr_valid=0.
halted  out  1  fetch stopped by HALT_OPCODE.

Behaviour:
- Registers: fetch_pc[7:0], pend_valid, hold_valid, hold_word[23:0], hold_pc[7:0], pend_pc[7:0], state in {RUN, STALL, REDIR, HALT}.
- Reset values: fetch_pc=RESET_VECTOR, pend_valid=0, hold_valid=0, hold_word=0, hold_pc=0, pend_pc=0, state=RUN.
- Reset outputs: rom_addr=RESET_VECTOR, rom_data=NOP_WORD, instr_valid=0, instr_pc=0, halted=0.
- Reset is synchronous. Asserting rst mid-operation discards pending, held and redirect state on that edge.
- Current word: if hold_valid, cur=hold_word and cur_pc=hold_pc. Otherwise cur=rom_rdata and cur_pc=pend_pc. cur_valid = hold_valid | pend_valid.
- Issue condition is issue = cur_valid & !stall & state!=HALT & cur[23:16]!=HALT_OPCODE. instr_valid=issue. rom_data = issue ? cur : NOP_WORD.
- jump_enable and jump_data are ignored unless issue=1.
- First valid instruction appears in the second cycle after rst deasserts.
- RUN, issue and no jump: pend_pc<=fetch_pc, fetch_pc<=fetch_pc+1, pend_valid<=1.
- RUN, issue and jump: fetch_pc<=jump_data, pend_valid<=0, go to REDIR. The sequential word in flight is squashed, so a taken jump costs 1 bubble.
- RUN, stall with cur_valid: hold_word<=cur, hold_pc<=cur_pc, hold_valid<=1. fetch_pc is unchanged and pend_pc<=fetch_pc. Go to STALL.
- RUN, !cur_valid: advance as in the no-jump case. stall has no effect.
- STALL, stall=1: all registers hold. rom_data=NOP_WORD.
- STALL, stall=0: issues the held word with no penalty. hold_valid<=0.
  - No jump: fetch_pc<=fetch_pc+1, pend_valid<=1, go to RUN.
  - Jump: fetch_pc<=jump_data, pend_valid<=0, go to REDIR.
- REDIR: rom_data=NOP_WORD. pend_pc<=fetch_pc, fetch_pc<=fetch_pc+1, pend_valid<=1, go to RUN. stall is ignored in REDIR.
- HALT entry: cur_valid & !stall and cur opcode == HALT_OPCODE go to HALT. The halt word itself is never issued.
- HALT: halted=1, rom_data=NOP_WORD, fetch_pc frozen. Exit only via rst.
- PC arithmetic is 8-bit modulo: fetch_pc 8'hFF+1 wraps to 8'h00. A jump to the current address is legal.

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_issued[15:0] and perf_bubbles[15:0].
- Both reset to 0 on rst and saturate at 16'hFFFF.
- perf_issued increments on each cycle with issue=1.
- perf_bubbles increments on each cycle with issue=0 while state!=HALT.
When undefined, neither the ports nor the counters exist. All other behaviour is identical.

Test Plan:
- Reset then run, ROM[0..3]=sequential non-jump words: instr_valid first 1 in the 2nd cycle after rst deassert. instr_pc sequence 0,1,2,3 on consecutive cycles; rom_addr leads instr_pc by 1.
- Jump at PC 2 with jump_data=8'h40: cycle after = NOP, instr_valid=0. Next cycle instr_pc=8'h40. The word at PC 3 is never issued.
- stall=1 for 3 cycles while instr_pc=5: rom_data=NOP_WORD for 3 cycles. On release PC 5 issues once, then 6 next cycle with no bubble. Also stall a jump word: the jump is taken only on the release cycle.
- Word with opcode 8'hFF at PC 7: PC 6 issues, then halted=1 permanently with rom_data=NOP_WORD. rst restarts at RESET_VECTOR.
- Wrap: jump to 8'hFE, sequential: instr_pc FE, FF, 00, 01.
- With FETCH_PERF_EN, 4 issues + 1 jump bubble + 2 stall cycles: perf_issued=4, perf_bubbles=3 + initial boot bubble(s).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency ROM, and hands one word per cycle to the decoder.
// Optional perf counters (perf_issued, perf_bubbles) are built only when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter logic [7:0]  RESET_VECTOR = 8'h00,
    parameter logic [23:0] NOP_WORD     = 24'h000000,
    parameter logic [7:0]  HALT_OPCODE  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  rom_addr,
    input  logic [23:0] rom_rdata,
    input  logic        stall,
    input  logic        jump_enable,
    input  logic [7:0]  jump_data,
    output logic [23:0] rom_data,
    output logic        instr_valid,
    output logic [7:0]  instr_pc,
    output logic        halted,
    output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_issued,
    output logic [15:0] perf_bubbles
`endif
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] REDIR = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]  state;
    logic [7:0]  fetch_pc;
    logic [7:0]  pend_pc;
    logic [7:0]  hold_pc;
    logic [23:0] hold_word;
    logic        pend_valid;
    logic        hold_valid;

    logic [23:0] cur_word;
    logic [7:0]  cur_pc;
    logic        cur_valid;
    logic        cur_halt;
    logic        issue;

    // Handshake: instr_valid=1 means rom_data/instr_pc carry a real instruction this
    // cycle; there is no ready, the decoder applies backpressure with stall, which
    // parks the current word in the hold register until stall drops.
    assign cur_word  = hold_valid ? hold_word : rom_rdata;
    assign cur_pc    = hold_valid ? hold_pc : pend_pc;
    assign cur_valid = hold_valid | pend_valid;
    assign cur_halt  = (cur_word[23:16] == HALT_OPCODE);
    assign issue     = cur_valid & ~stall & (state != HALT) & ~cur_halt;

    assign rom_addr    = fetch_pc;
    assign instr_valid = issue;
    assign rom_data    = issue ? cur_word : NOP_WORD;
    assign instr_pc    = issue ? cur_pc : 8'h00;
    assign halted      = (state == HALT);
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            fetch_pc   <= RESET_VECTOR;
            pend_pc    <= 8'h00;
            pend_valid <= 1'b0;
            hold_valid <= 1'b0;
            hold_word  <= 24'h000000;
            hold_pc    <= 8'h00;
        end else begin
            case (state)
                RUN: begin
                    if (cur_valid & ~stall & cur_halt) begin
                        state <= HALT;
                    end else if (issue & jump_enable) begin
                        // The sequential word already in flight is squashed.
                        fetch_pc   <= jump_data;
                        pend_valid <= 1'b0;
                        state      <= REDIR;
                    end else if (cur_valid & stall) begin
                        hold_word  <= cur_word;
                        hold_pc    <= cur_pc;
                        hold_valid <= 1'b1;
                        pend_pc    <= fetch_pc;
                        state      <= STALL;
                    end else begin
                        pend_pc    <= fetch_pc;
                        fetch_pc   <= fetch_pc + 8'd1;
                        pend_valid <= 1'b1;
                    end
                end
                STALL: begin
                    if (~stall) begin
                        hold_valid <= 1'b0;
                        if (cur_halt) begin
                            state <= HALT;
                        end else if (jump_enable) begin
                            fetch_pc   <= jump_data;
                            pend_valid <= 1'b0;
                            state      <= REDIR;
                        end else begin
                            // ROM already holds the word at fetch_pc, so no bubble.
                            fetch_pc   <= fetch_pc + 8'd1;
                            pend_valid <= 1'b1;
                            state      <= RUN;
                        end
                    end
                end
                REDIR: begin
                    pend_pc    <= fetch_pc;
                    fetch_pc   <= fetch_pc + 8'd1;
                    pend_valid <= 1'b1;
                    state      <= RUN;
                end
                HALT: begin
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued  <= 16'h0000;
            perf_bubbles <= 16'h0000;
        end else begin
            if (issue && perf_issued != 16'hFFFF) begin
                perf_issued <= perf_issued + 16'd1;
            end
            if (!issue && state != HALT && perf_bubbles != 16'hFFFF) begin
                perf_bubbles <= perf_bubbles + 16'd1;
            end
        end
    end
`endif

endmodule
